// File: rtl/snif_mc_pkg.sv
// -----------------------------------------------------------------------------
// snif_mc_pkg
// Shared definitions for the multi-channel bus sniffer:
//   - SNIF_MODE_* channel mode encodings (off / rise / fall / both)
//   - default address width
//   - snif_edge_sel(): picks the channel event from the rise/fall terms
// -----------------------------------------------------------------------------
package snif_mc_pkg;

  localparam int SNIF_ADR_WIDTH_DEF = 32;

  typedef enum logic [1:0] {
    SNIF_MODE_OFF  = 2'b00,
    SNIF_MODE_RISE = 2'b01,
    SNIF_MODE_FALL = 2'b10,
    SNIF_MODE_BOTH = 2'b11
  } snif_mode_e;

  // Event seen by a channel for the given mode and edge terms.
  function automatic logic snif_edge_sel(input snif_mode_e mode,
                                         input logic       rise,
                                         input logic       fall);
    logic ev;
    case (mode)
      SNIF_MODE_OFF:  ev = 1'b0;
      SNIF_MODE_RISE: ev = rise;
      SNIF_MODE_FALL: ev = fall;
      SNIF_MODE_BOTH: ev = rise | fall;
      default:        ev = 1'b0;
    endcase
    return ev;
  endfunction

endpackage

// File: rtl/snif_ch.sv
// -----------------------------------------------------------------------------
// snif_ch -- one sniffer match channel
// Compares the bus address against a masked match value on write cycles,
// keeps the previous hit (hit_q), turns rise/fall of the hit into an event
// according to the mode, and counts (saturating) / flags (sticky) events.
// Ports:
//   clk_i, rst_ni          clock, synchronous active-low reset
//   adr_i, stb_i, we_i     sniffed bus cycle
//   match_i, mask_i        compare value and mask (1 = bit compared)
//   mode_i                 event selection
//   clr_i                  clear counter and pending flag
//   detect_o               one-cycle event pulse (1 cycle after the event)
//   pending_o              sticky event flag
//   cnt_o                  saturating event counter
// -----------------------------------------------------------------------------
module snif_ch
  import snif_mc_pkg::*;
#(
  parameter int ADR_WIDTH = SNIF_ADR_WIDTH_DEF,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [ADR_WIDTH-1:0] adr_i,
  input  logic                 stb_i,
  input  logic                 we_i,
  input  logic [ADR_WIDTH-1:0] match_i,
  input  logic [ADR_WIDTH-1:0] mask_i,
  input  snif_mode_e           mode_i,
  input  logic                 clr_i,
  output logic                 detect_o,
  output logic                 pending_o,
  output logic [CNT_WIDTH-1:0] cnt_o
);

  logic                 w_hit;
  logic                 w_rise;
  logic                 w_fall;
  logic                 w_event;
  logic                 r_hit_q;
  logic                 r_detect;
  logic                 r_pending;
  logic [CNT_WIDTH-1:0] r_cnt;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    if (v == {CNT_WIDTH{1'b1}}) begin
      return v;
    end else begin
      return v + CNT_WIDTH'(1);
    end
  endfunction

  // Only write cycles can hit; masked-out bits never cause a mismatch.
  assign w_hit   = stb_i & we_i & (((adr_i ^ match_i) & mask_i) == {ADR_WIDTH{1'b0}});
  assign w_rise  = w_hit & ~r_hit_q;
  assign w_fall  = r_hit_q & ~w_hit;
  // Mode acts on the current cycle; hit_q history is kept regardless of mode.
  assign w_event = snif_edge_sel(mode_i, w_rise, w_fall);

  // Hit history, detect pulse, counter and pending flag.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_hit_q   <= 1'b0;
      r_detect  <= 1'b0;
      r_pending <= 1'b0;
      r_cnt     <= {CNT_WIDTH{1'b0}};
    end else begin
      r_hit_q  <= w_hit;
      r_detect <= w_event;
      if (w_event) begin
        // An event in the clear cycle wins: the clear drops older history only.
        r_pending <= 1'b1;
        r_cnt     <= clr_i ? CNT_WIDTH'(1) : sat_inc(r_cnt);
      end else if (clr_i) begin
        r_pending <= 1'b0;
        r_cnt     <= {CNT_WIDTH{1'b0}};
      end
    end
  end

  assign detect_o  = r_detect;
  assign pending_o = r_pending;
  assign cnt_o     = r_cnt;

endmodule

// File: rtl/snif_mc.sv
// -----------------------------------------------------------------------------
// snif_mc -- multi-channel bus address sniffer
// NCH independent snif_ch channels watch the same bus; this level only slices
// the packed per-channel vectors and reduces the interrupt.
// Ports:
//   clk_i, rst_ni               clock, synchronous active-low reset
//   adr_i, stb_i, we_i          sniffed bus cycle
//   match_i, mask_i             per-channel compare value / mask, ADR_WIDTH each
//   mode_i                      per-channel mode, 2 bits each
//   clr_i, irq_en_i             per-channel clear / interrupt enable
//   detect_o, pending_o, cnt_o  per-channel status (cnt CNT_WIDTH each)
//   irq_o                       OR of pending & irq_en
// -----------------------------------------------------------------------------
module snif_mc
  import snif_mc_pkg::*;
#(
  parameter int ADR_WIDTH = SNIF_ADR_WIDTH_DEF,
  parameter int NCH       = 4,
  parameter int CNT_WIDTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [ADR_WIDTH-1:0]     adr_i,
  input  logic                     stb_i,
  input  logic                     we_i,
  input  logic [NCH*ADR_WIDTH-1:0] match_i,
  input  logic [NCH*ADR_WIDTH-1:0] mask_i,
  input  logic [2*NCH-1:0]         mode_i,
  input  logic [NCH-1:0]           clr_i,
  input  logic [NCH-1:0]           irq_en_i,
  output logic [NCH-1:0]           detect_o,
  output logic [NCH-1:0]           pending_o,
  output logic [NCH*CNT_WIDTH-1:0] cnt_o,
  output logic                     irq_o
);

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    snif_ch #(
      .ADR_WIDTH (ADR_WIDTH),
      .CNT_WIDTH (CNT_WIDTH)
    ) u_ch (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .adr_i     (adr_i),
      .stb_i     (stb_i),
      .we_i      (we_i),
      .match_i   (match_i[c*ADR_WIDTH +: ADR_WIDTH]),
      .mask_i    (mask_i[c*ADR_WIDTH +: ADR_WIDTH]),
      .mode_i    (snif_mode_e'(mode_i[2*c +: 2])),
      .clr_i     (clr_i[c]),
      .detect_o  (detect_o[c]),
      .pending_o (pending_o[c]),
      .cnt_o     (cnt_o[c*CNT_WIDTH +: CNT_WIDTH])
    );
  end

  // Combinational from registered pending: no extra cycle of latency.
  assign irq_o = |(pending_o & irq_en_i);

endmodule

// File: tb/tb_snif_mc.sv
module tb_snif_mc;

  localparam int AW  = 32;
  localparam int NCH = 4;
  localparam int CW  = 8;

  logic              clk = 1'b0;
  logic              rst_ni;
  logic [AW-1:0]     adr;
  logic              stb;
  logic              we;
  logic [NCH*AW-1:0] match;
  logic [NCH*AW-1:0] mask;
  logic [2*NCH-1:0]  mode;
  logic [NCH-1:0]    clr;
  logic [NCH-1:0]    irq_en;
  logic [NCH-1:0]    detect;
  logic [NCH-1:0]    pending;
  logic [NCH*CW-1:0] cnt;
  logic              irq;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    int ch;
    int at;
    int cnt;
    int pend;
  } exp_t;

  exp_t sb[$];

  snif_mc #(.ADR_WIDTH(AW), .NCH(NCH), .CNT_WIDTH(CW)) dut (
    .clk_i     (clk),
    .rst_ni    (rst_ni),
    .adr_i     (adr),
    .stb_i     (stb),
    .we_i      (we),
    .match_i   (match),
    .mask_i    (mask),
    .mode_i    (mode),
    .clr_i     (clr),
    .irq_en_i  (irq_en),
    .detect_o  (detect),
    .pending_o (pending),
    .cnt_o     (cnt),
    .irq_o     (irq)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input longint act, input longint exp_v);
    total++;
    if (act != exp_v) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp_v, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic [AW-1:0] a, input logic s, input logic w);
    adr = a;
    stb = s;
    we  = w;
  endtask

  task automatic push(input int ch, input int at, input int c, input int p);
    exp_t e;
    e.ch = ch; e.at = at; e.cnt = c; e.pend = p;
    sb.push_back(e);
  endtask

  function automatic int cnt_of(input int c);
    return int'(cnt[c*CW +: CW]);
  endfunction

  // Monitor: every detect pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].at < cyc) begin
      total++;
      bad++;
      $display("FAIL missing_detect: ch%0d expected at cycle %0d, no pulse by cycle %0d",
               sb[0].ch, sb[0].at, cyc);
      void'(sb.pop_front());
    end
    for (int c = 0; c < NCH; c++) begin
      if (detect[c]) begin
        if (sb.size() == 0 || sb[0].ch != c || sb[0].at != cyc) begin
          total++;
          bad++;
          $display("FAIL unexpected_detect: ch%0d at cycle %0d, required none", c, cyc);
        end else begin
          chk($sformatf("det_cnt_ch%0d", c), cnt_of(c), sb[0].cnt);
          chk($sformatf("det_pend_ch%0d", c), pending[c], sb[0].pend);
          void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    rst_ni = 1'b0;
    drv(32'h0, 1'b0, 1'b0);
    match  = '0;
    mask   = '0;
    mode   = 8'h00;
    clr    = 4'h0;
    irq_en = 4'h0;

    // Reset state
    repeat (3) step();
    chk("rst_detect", detect, 0);
    chk("rst_pending", pending, 0);
    chk("rst_cnt", cnt, 0);
    chk("rst_irq", irq, 0);
    rst_ni = 1'b1;
    step();

    // ch0 fall mode: 3-cycle write burst -> single detect one cycle after burst end
    match[0*AW +: AW] = 32'h0000_1000;
    mask[0*AW +: AW]  = 32'hFFFF_FFFF;
    mode[1:0]         = 2'b10;
    step();
    drv(32'h1000, 1'b1, 1'b1);
    push(0, cyc + 4, 1, 1);
    repeat (3) step();
    drv(32'h0, 1'b0, 1'b0);
    repeat (4) step();
    mode[1:0] = 2'b00;

    // ch1 both-edges mode: single write -> detect on two consecutive cycles
    match[1*AW +: AW] = 32'h0000_3000;
    mask[1*AW +: AW]  = 32'hFFFF_FFFF;
    mode[3:2]         = 2'b11;
    step();
    drv(32'h3000, 1'b1, 1'b1);
    push(1, cyc + 1, 1, 1);
    push(1, cyc + 2, 2, 1);
    step();
    drv(32'h0, 1'b0, 1'b0);
    repeat (3) step();
    mode[3:2] = 2'b00;

    // ch2 rise mode: 300 isolated writes, counter saturates at 255
    match[2*AW +: AW] = 32'h0000_4000;
    mask[2*AW +: AW]  = 32'hFFFF_FFFF;
    mode[5:4]         = 2'b01;
    step();
    for (int i = 0; i < 300; i++) begin
      drv(32'h4000, 1'b1, 1'b1);
      push(2, cyc + 1, (i + 1 > 255) ? 255 : i + 1, 1);
      step();
      drv(32'h0, 1'b0, 1'b0);
      step();
    end
    step();
    chk("sat_cnt_ch2", cnt_of(2), 255);
    mode[5:4] = 2'b00;

    // ch0 clear: alone, then simultaneous with an event (event wins)
    mode[1:0] = 2'b01;
    clr = 4'h1;
    step();
    clr = 4'h0;
    chk("clr_cnt_ch0", cnt_of(0), 0);
    chk("clr_pend_ch0", pending[0], 0);
    drv(32'h1000, 1'b1, 1'b1);
    push(0, cyc + 1, 1, 1);
    step();
    drv(32'h0, 1'b0, 1'b0);
    repeat (2) step();
    drv(32'h1000, 1'b1, 1'b1);
    clr = 4'h1;
    push(0, cyc + 1, 1, 1);
    step();
    drv(32'h0, 1'b0, 1'b0);
    clr = 4'h0;
    repeat (2) step();
    clr = 4'h1;
    step();
    clr = 4'h0;
    chk("clr2_cnt_ch0", cnt_of(0), 0);
    chk("clr2_pend_ch0", pending[0], 0);

    // ch0 mode switch rise->fall mid-burst: rise at start, fall at end
    drv(32'h1000, 1'b1, 1'b1);
    push(0, cyc + 1, 1, 1);
    step();
    mode[1:0] = 2'b10;
    repeat (2) step();
    drv(32'h0, 1'b0, 1'b0);
    push(0, cyc + 1, 2, 1);
    repeat (2) step();
    mode[1:0] = 2'b00;

    // ch3 partial mask, read ignored, irq follows pending & enable
    match[3*AW +: AW] = 32'h0000_2000;
    mask[3*AW +: AW]  = 32'hFFFF_FF00;
    mode[7:6]         = 2'b01;
    irq_en            = 4'h8;
    step();
    chk("irq_idle", irq, 0);
    drv(32'h2000, 1'b1, 1'b0);
    step();
    drv(32'h0, 1'b0, 1'b0);
    chk("read_nohit_cnt_ch3", cnt_of(3), 0);
    chk("read_nohit_pend_ch3", pending[3], 0);
    drv(32'h20AB, 1'b1, 1'b1);
    push(3, cyc + 1, 1, 1);
    step();
    drv(32'h0, 1'b0, 1'b0);
    chk("irq_set", irq, 1);
    step();
    clr = 4'h8;
    step();
    clr = 4'h0;
    chk("irq_clr", irq, 0);
    chk("clr_cnt_ch3", cnt_of(3), 0);
    mode[7:6] = 2'b00;

    // Reset in the middle of a ch1 burst, released with hit still active
    mode[3:2] = 2'b11;
    irq_en    = 4'hF;
    step();
    drv(32'h3000, 1'b1, 1'b1);
    push(1, cyc + 1, 3, 1);
    repeat (2) step();
    rst_ni = 1'b0;
    step();
    chk("mid_rst_detect", detect, 0);
    chk("mid_rst_pending", pending, 0);
    chk("mid_rst_cnt", cnt, 0);
    chk("mid_rst_irq", irq, 0);
    step();
    chk("mid_rst_detect2", detect, 0);
    rst_ni = 1'b1;
    push(1, cyc + 1, 1, 1);
    step();
    step();
    drv(32'h0, 1'b0, 1'b0);
    push(1, cyc + 1, 2, 1);
    repeat (3) step();
    chk("post_rst_irq", irq, 1);

    chk("sb_drain", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
